// File: rtl/tanh_lut_writer.sv
// rtl/tanh_lut_writer.sv - tanh table loader: validates a sample stream and writes it into a dual-read RAM
module tanh_lut_writer #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int N  = 32,
  parameter int Q  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b,
  output logic          busy,
  output logic          table_valid,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW:0]   wr_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [DW-1:0] ONE       = {{(DW-1){1'b0}}, 1'b1} << Q;

  localparam logic [1:0] CODE_RANGE = 2'd0;
  localparam logic [1:0] CODE_MONO  = 2'd1;
  localparam logic [1:0] CODE_SHORT = 2'd2;
  localparam logic [1:0] CODE_LONG  = 2'd3;

  state_t        state, state_next;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] prev;
  logic [1:0]    code_next;
  logic          accept;
  logic          range_bad;
  logic          mono_bad;
  logic          do_write;
  logic          do_init;

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] rd_addr_b;

  assign accept    = s_valid & s_ready;
  assign range_bad = s_data[N-1] | (s_data > ONE);
  assign mono_bad  = $signed(s_data) < $signed(prev);
  assign rd_addr_b = rd_addr + 1'b1;

  assign busy        = (state == LOAD);
  assign table_valid = (state == DONE);
  assign err         = (state == ERROR);

  always_comb begin
    state_next = state;
    code_next  = err_code;
    do_write   = 1'b0;
    do_init    = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next = LOAD;
          do_init    = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          if (range_bad) begin
            state_next = ERROR;
            code_next  = CODE_RANGE;
          end else if (mono_bad) begin
            state_next = ERROR;
            code_next  = CODE_MONO;
          end else begin
            // Length faults still commit the word; only value faults drop it.
            do_write = 1'b1;
            if (s_last && (wr_addr != LAST_ADDR)) begin
              state_next = ERROR;
              code_next  = CODE_SHORT;
            end else if ((wr_addr == LAST_ADDR) && !s_last) begin
              state_next = ERROR;
              code_next  = CODE_LONG;
            end else if (wr_addr == LAST_ADDR) begin
              state_next = DONE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      wr_addr  <= '0;
      wr_count <= '0;
      prev     <= '0;
      err_code <= 2'd0;
    end else begin
      state    <= state_next;
      err_code <= code_next;
      // Ready only once LOAD is established and drops as soon as LOAD is left.
      s_ready  <= (state == LOAD) && (state_next == LOAD);
      if (do_init) begin
        wr_addr  <= '0;
        wr_count <= '0;
        prev     <= '0;
      end else if (do_write) begin
        wr_addr  <= wr_addr + 1'b1;
        wr_count <= wr_count + 1'b1;
        prev     <= s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_addr] <= s_data;
    end
  end

  // Output registers read the array before any same-cycle write lands (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= mem[rd_addr];
      rd_data_b <= mem[rd_addr_b];
    end
  end

endmodule

// File: tb/tb_tanh_lut_writer.sv
// tb/tb_tanh_lut_writer.sv - directed self-checking bench for tanh_lut_writer
module tb_tanh_lut_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        busy;
  logic        table_valid;
  logic        err;
  logic [1:0]  err_code;
  logic [10:0] wr_count;

  logic [31:0] vals [1024];
  int          passed;
  int          failed;
  int          total;
  int          n_acc;

  localparam int LIMIT = 6000;

  tanh_lut_writer dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .busy(busy), .table_valid(table_valid), .err(err),
    .err_code(err_code), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ramp(input int step);
    for (int i = 0; i < 1024; i++) vals[i] = i * step;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives vals[first..count-1] from a negedge; stops early when the writer leaves LOAD.
  task automatic run_stream(input int first, input int count, input int last_at, input bit toggle);
    int  idx;
    int  cyc;
    logic acc;
    idx = first;
    cyc = 0;
    while (idx < count && !err && !table_valid && cyc < LIMIT) begin
      s_valid = toggle ? ~cyc[0] : 1'b1;
      s_data  = vals[idx];
      s_last  = (idx == last_at);
      acc     = s_valid & s_ready;
      @(negedge clk);
      if (acc) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_acc   = idx;
    check("stream_bound", 32'(cyc < LIMIT), 32'd1);
  endtask

  task automatic read_pair(input string tag, input int addr, input logic [31:0] ea, input logic [31:0] eb);
    rd_addr = 10'(addr);
    @(negedge clk);
    check({tag, "_a"}, rd_data_a, ea);
    check({tag, "_b"}, rd_data_b, eb);
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; rd_addr = '0;
    #1;
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_table_valid", 32'(table_valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_rd_a", rd_data_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full continuous load
    set_ramp(64);
    pulse_start();
    check("load_busy", 32'(busy), 1);
    check("load_ready_delayed", 32'(s_ready), 0);
    run_stream(0, 1024, 1023, 1'b0);
    check("full_table_valid", 32'(table_valid), 1);
    check("full_wr_count", 32'(wr_count), 1024);
    check("full_err", 32'(err), 0);
    check("full_ready_low", 32'(s_ready), 0);
    read_pair("full_rd5", 5, 32'd320, 32'd384);
    read_pair("full_rd1023", 1023, 32'h0000_FFC0, 32'h0);

    // LONG: s_last never asserted
    set_ramp(32);
    pulse_start();
    run_stream(0, 1024, -1, 1'b0);
    check("long_err", 32'(err), 1);
    check("long_code", 32'(err_code), 3);
    check("long_wr_count", 32'(wr_count), 1024);
    check("long_ready_low", 32'(s_ready), 0);
    read_pair("long_rd5", 5, 32'd160, 32'd192);

    // Backpressure ramp restores the i*64 table
    set_ramp(64);
    pulse_start();
    run_stream(0, 1024, 1023, 1'b1);
    check("bp_table_valid", 32'(table_valid), 1);
    check("bp_wr_count", 32'(wr_count), 1024);
    read_pair("bp_rd5", 5, 32'd320, 32'd384);
    read_pair("bp_rd512", 512, 32'd32768, 32'd32832);
    read_pair("bp_rd1023", 1023, 32'h0000_FFC0, 32'h0);

    // RANGE above ONE
    set_ramp(16);
    vals[3] = 32'h0001_0001;
    pulse_start();
    run_stream(0, 1024, 1023, 1'b0);
    check("range1_err", 32'(err), 1);
    check("range1_code", 32'(err_code), 0);
    check("range1_wr_count", 32'(wr_count), 3);
    check("range1_ready_low", 32'(s_ready), 0);
    check("range1_table_valid", 32'(table_valid), 0);
    read_pair("range1_rd2", 2, 32'd32, 32'd192);

    // RANGE negative
    set_ramp(8);
    vals[3] = 32'hFFFF_0000;
    pulse_start();
    run_stream(0, 1024, 1023, 1'b0);
    check("range2_code", 32'(err_code), 0);
    check("range2_wr_count", 32'(wr_count), 3);
    read_pair("range2_rd2", 2, 32'd16, 32'd192);

    // Exactly ONE is legal and equal samples are non-decreasing; ends SHORT
    vals[0] = 32'h0; vals[1] = 32'h0001_0000; vals[2] = 32'h0001_0000;
    pulse_start();
    run_stream(0, 3, 2, 1'b0);
    check("one_code", 32'(err_code), 2);
    check("one_wr_count", 32'(wr_count), 3);
    read_pair("one_rd1", 1, 32'h0001_0000, 32'h0001_0000);

    // MONO
    vals[0] = 32'h100; vals[1] = 32'h200; vals[2] = 32'h1FF;
    pulse_start();
    run_stream(0, 3, -1, 1'b0);
    check("mono_err", 32'(err), 1);
    check("mono_code", 32'(err_code), 1);
    check("mono_wr_count", 32'(wr_count), 2);
    read_pair("mono_rd1", 1, 32'h200, 32'h0001_0000);

    // SHORT after restart
    set_ramp(64);
    pulse_start();
    check("restart_err_clear", 32'(err), 0);
    run_stream(0, 1024, 9, 1'b0);
    check("short_code", 32'(err_code), 2);
    check("short_wr_count", 32'(wr_count), 10);
    check("short_ready_low", 32'(s_ready), 0);

    // Reset mid-load
    pulse_start();
    run_stream(0, 500, 1023, 1'b0);
    check("mid_wr_count", 32'(wr_count), 500);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(s_ready), 0);
    check("mid_rst_err_code", 32'(err_code), 0);
    check("mid_rst_wr_count", 32'(wr_count), 0);
    check("mid_rst_rd_b", rd_data_b, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reload with a start pulse ignored during LOAD
    pulse_start();
    run_stream(0, 300, 1023, 1'b0);
    pulse_start();
    check("ign_start_wr_count", 32'(wr_count), 300);
    check("ign_start_busy", 32'(busy), 1);
    run_stream(300, 1024, 1023, 1'b0);
    check("reload_table_valid", 32'(table_valid), 1);
    check("reload_wr_count", 32'(wr_count), 1024);
    read_pair("reload_rd400", 400, 32'd25600, 32'd25664);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
